// File: rtl/hub75_panel_receiver.sv
// Panel-side HUB75 capture: synchronises the link pins, rebuilds each latched line pair and
// streams it out as (x,y,rgb) pixels, and measures how long OE stayed asserted.
module hub75_panel_receiver #(
    parameter int COLUMNS     = 64,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hub_clk,
    input  logic                       hub_latch,
    input  logic                       hub_oe,
    input  logic [ADDR_W-1:0]          hub_addr,
    input  logic [2:0]                 hub_rgb0,
    input  logic [2:0]                 hub_rgb1,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [$clog2(COLUMNS)-1:0] pix_x,
    output logic [ADDR_W:0]            pix_y,
    output logic [2:0]                 pix_rgb,
    output logic                       line_done,
    output logic [15:0]                oe_cycles,
    output logic                       oe_valid,
    output logic                       err_len,
    output logic                       err_overrun,
    output logic [1:0]                 dbg_state
);
    localparam int XW = $clog2(COLUMNS);
    localparam int CW = XW + 1;
    localparam int BW = 2 + ADDR_W + 6;

    typedef enum logic [1:0] {IDLE = 2'd0, TOP = 2'd1, BOT = 2'd2} state_t;

    // Data pins share the clk/latch chain depth so they arrive aligned with the edges.
    logic [BW-1:0]          bus_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] oe_sync;
    logic                   clk_s, latch_s, oe_s;
    logic [ADDR_W-1:0]      addr_s;
    logic [2:0]             rgb0_s, rgb1_s;
    logic                   clk_d, latch_d, oe_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) bus_sync[i] <= '0;
            oe_sync <= '1;
            clk_d   <= 1'b0;
            latch_d <= 1'b0;
            oe_d    <= 1'b1;
        end else begin
            bus_sync[0] <= {hub_clk, hub_latch, hub_addr, hub_rgb0, hub_rgb1};
            for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
            oe_sync <= {oe_sync[SYNC_STAGES-2:0], hub_oe};
            clk_d   <= clk_s;
            latch_d <= latch_s;
            oe_d    <= oe_s;
        end
    end

    assign {clk_s, latch_s, addr_s, rgb0_s, rgb1_s} = bus_sync[SYNC_STAGES-1];
    assign oe_s = oe_sync[SYNC_STAGES-1];

    logic clk_rise, latch_rise, oe_fall, oe_rise;
    assign clk_rise   = clk_s & ~clk_d;
    assign latch_rise = latch_s & ~latch_d;
    assign oe_fall    = ~oe_s & oe_d;
    assign oe_rise    = oe_s & ~oe_d;

    state_t          state, state_nx;
    logic [2:0]      sh0 [COLUMNS];
    logic [2:0]      sh1 [COLUMNS];
    logic [2:0]      line0 [COLUMNS];
    logic [2:0]      line1 [COLUMNS];
    logic [CW-1:0]   col_cnt, col_eff;
    logic            ovf, ovf_eff, shift_wr, take_line;
    logic [ADDR_W-1:0] row;

    // col_eff/ovf_eff fold in a shift edge arriving together with the latch edge.
    assign shift_wr  = clk_rise && (col_cnt < CW'(COLUMNS));
    assign col_eff   = shift_wr ? col_cnt + CW'(1) : col_cnt;
    assign ovf_eff   = ovf | (clk_rise & ~shift_wr);
    assign take_line = latch_rise && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COLUMNS; i++) begin
                sh0[i]   <= '0;
                sh1[i]   <= '0;
                line0[i] <= '0;
                line1[i] <= '0;
            end
            col_cnt     <= '0;
            ovf         <= 1'b0;
            row         <= '0;
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
            if (take_line) begin
                for (int i = 0; i < COLUMNS; i++) begin
                    line0[i] <= (shift_wr && col_cnt[XW-1:0] == XW'(i)) ? rgb0_s : sh0[i];
                    line1[i] <= (shift_wr && col_cnt[XW-1:0] == XW'(i)) ? rgb1_s : sh1[i];
                    sh0[i]   <= '0;
                    sh1[i]   <= '0;
                end
                row     <= addr_s;
                err_len <= (col_eff != CW'(COLUMNS)) || ovf_eff;
                col_cnt <= '0;
                ovf     <= 1'b0;
            end else begin
                // A latch refused mid-drain leaves the partial shift intact for the next latch.
                if (shift_wr) begin
                    sh0[col_cnt[XW-1:0]] <= rgb0_s;
                    sh1[col_cnt[XW-1:0]] <= rgb1_s;
                end
                col_cnt     <= col_eff;
                ovf         <= ovf_eff;
                err_overrun <= latch_rise;
            end
        end
    end

    // pix_valid/pix_ready: a pixel transfers on any cycle where both are high; while
    // pix_valid && !pix_ready the current x/y/rgb are held unchanged.
    logic [XW-1:0] x_cnt, x_nx;
    logic          done_nx, accept, draining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_cnt     <= '0;
            line_done <= 1'b0;
        end else begin
            state     <= state_nx;
            x_cnt     <= x_nx;
            line_done <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        x_nx      = x_cnt;
        done_nx   = 1'b0;
        draining  = (state == TOP) || (state == BOT);
        accept    = draining && pix_ready;
        pix_valid = draining;
        pix_x     = x_cnt;
        pix_y     = '0;
        pix_rgb   = '0;
        case (state)
            IDLE: begin
                if (take_line) begin
                    state_nx = TOP;
                    x_nx     = '0;
                end
            end
            TOP: begin
                pix_y   = {1'b0, row};
                pix_rgb = line0[x_cnt];
                if (accept) begin
                    if (x_cnt == XW'(COLUMNS - 1)) begin
                        x_nx     = '0;
                        state_nx = BOT;
                    end else begin
                        x_nx = x_cnt + XW'(1);
                    end
                end
            end
            BOT: begin
                pix_y   = {1'b1, row};
                pix_rgb = line1[x_cnt];
                if (accept) begin
                    if (x_cnt == XW'(COLUMNS - 1)) begin
                        x_nx     = '0;
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        x_nx = x_cnt + XW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign dbg_state = state;

    // The falling-edge cycle is itself the first low cycle, hence the load of 1.
    logic [15:0] oe_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_cnt    <= '0;
            oe_cycles <= '0;
            oe_valid  <= 1'b0;
        end else begin
            oe_valid <= 1'b0;
            if (oe_fall)
                oe_cnt <= 16'd1;
            else if (!oe_s && oe_cnt != 16'hFFFF)
                oe_cnt <= oe_cnt + 16'd1;
            if (oe_rise) begin
                oe_cycles <= oe_cnt;
                oe_valid  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Bench for hub75_panel_receiver: drives HUB75 pins, scoreboards the pixel stream and checks
// length/overrun/OE/reset behaviour.
module tb_hub75_panel_receiver;
    localparam int COLUMNS = 64;
    localparam int ADDR_W  = 4;
    localparam int XW      = 6;
    localparam int PW      = XW + ADDR_W + 1 + 3;

    logic              clk, rst;
    logic              hub_clk, hub_latch, hub_oe;
    logic [ADDR_W-1:0] hub_addr;
    logic [2:0]        hub_rgb0, hub_rgb1;
    logic              pix_valid, pix_ready;
    logic [XW-1:0]     pix_x;
    logic [ADDR_W:0]   pix_y;
    logic [2:0]        pix_rgb;
    logic              line_done, oe_valid, err_len, err_overrun;
    logic [15:0]       oe_cycles;
    logic [1:0]        dbg_state;

    hub75_panel_receiver #(.COLUMNS(COLUMNS), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_latch(hub_latch), .hub_oe(hub_oe),
        .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .line_done(line_done), .oe_cycles(oe_cycles), .oe_valid(oe_valid),
        .err_len(err_len), .err_overrun(err_overrun), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] exp_q[$];
    logic [2:0] top_exp [COLUMNS];
    logic [2:0] bot_exp [COLUMNS];
    int n_line_done, n_err_len, n_err_overrun, n_oe_valid, n_acc, first_acc, last_acc;
    int cyc = 0;
    logic [15:0] last_oe;
    bit ready_toggle = 0;
    logic stall_prev = 0;
    logic [PW-1:0] stall_pix, got_pix, want_pix;

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ready_toggle ? ~pix_ready : 1'b1;
        end
    end

    // scoreboard: pops one expectation per accepted pixel, and checks stall stability
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (line_done) n_line_done++;
            if (err_len) n_err_len++;
            if (err_overrun) n_err_overrun++;
            if (oe_valid) begin
                n_oe_valid++;
                last_oe = oe_cycles;
            end
            got_pix = {pix_x, pix_y, pix_rgb};
            if (stall_prev) begin
                checks++;
                if (pix_valid !== 1'b1 || got_pix !== stall_pix) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%0b pix=%h required valid=1 pix=%h",
                             pix_valid, got_pix, stall_pix);
                end
            end
            if (pix_valid && pix_ready) begin
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pixel_extra got x=%0d y=%0d rgb=%0d required none",
                             pix_x, pix_y, pix_rgb);
                end else begin
                    want_pix = exp_q.pop_front();
                    if (got_pix !== want_pix) begin
                        failures++;
                        $display("FAIL pixel got x=%0d y=%0d rgb=%0d required x=%0d y=%0d rgb=%0d",
                                 pix_x, pix_y, pix_rgb, want_pix[PW-1 -: XW],
                                 want_pix[3 +: ADDR_W+1], want_pix[2:0]);
                    end
                end
            end
            stall_prev = pix_valid && !pix_ready;
            stall_pix  = got_pix;
        end
    end

    // driver tasks
    task automatic clear_counts();
        n_line_done = 0; n_err_len = 0; n_err_overrun = 0; n_oe_valid = 0; n_acc = 0;
    endtask

    task automatic shift_col(input logic [2:0] r0, input logic [2:0] r1);
        @(negedge clk);
        hub_rgb0 = r0;
        hub_rgb1 = r1;
        repeat (2) @(negedge clk);
        hub_clk = 1'b1;
        repeat (2) @(negedge clk);
        hub_clk = 1'b0;
    endtask

    task automatic pulse_latch(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        hub_addr = a;
        repeat (2) @(negedge clk);
        hub_latch = 1'b1;
        repeat (2) @(negedge clk);
        hub_latch = 1'b0;
    endtask

    task automatic push_line(input logic [ADDR_W-1:0] r);
        for (int x = 0; x < COLUMNS; x++) exp_q.push_back({XW'(x), 1'b0, r, top_exp[x]});
        for (int x = 0; x < COLUMNS; x++) exp_q.push_back({XW'(x), 1'b1, r, bot_exp[x]});
    endtask

    task automatic random_line();
        for (int i = 0; i < COLUMNS; i++) begin
            top_exp[i] = 3'($urandom_range(0, 7));
            bot_exp[i] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (6) @(negedge clk);
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_valid, line_done, oe_valid, err_len, err_overrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got %b required 00000",
                     {pix_valid, line_done, oe_valid, err_len, err_overrun});
        end
        checks++;
        if ({pix_x, pix_y, pix_rgb} !== '0) begin
            failures++;
            $display("FAIL reset_pixel got x=%0d y=%0d rgb=%0d required 0", pix_x, pix_y, pix_rgb);
        end
        checks++;
        if (oe_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_oe_cycles got %0d required 0", oe_cycles);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got %0d required 0", dbg_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        clear_counts();
        repeat (1000) begin
            @(negedge clk);
            if (pix_valid !== 1'b0 || dbg_state !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0 || n_line_done + n_err_len + n_err_overrun + n_oe_valid != 0) begin
            failures++;
            $display("FAIL idle_quiet got bad=%0d pulses=%0d required 0 0", bad,
                     n_line_done + n_err_len + n_err_overrun + n_oe_valid);
        end
    endtask

    task automatic test_full_line();
        clear_counts();
        for (int i = 0; i < COLUMNS; i++) begin
            top_exp[i] = i[2:0];
            bot_exp[i] = ~i[2:0];
        end
        push_line(4'd3);
        for (int i = 0; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        pulse_latch(4'd3);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || n_acc != 2 * COLUMNS) begin
            failures++;
            $display("FAIL full_count got left=%0d acc=%0d required 0 128", exp_q.size(), n_acc);
        end
        checks++;
        if (last_acc - first_acc != 2 * COLUMNS - 1) begin
            failures++;
            $display("FAIL full_no_bubble got span=%0d required 127", last_acc - first_acc);
        end
        checks++;
        if (n_line_done != 1 || n_err_len != 0 || n_err_overrun != 0) begin
            failures++;
            $display("FAIL full_pulses got done=%0d len=%0d ovr=%0d required 1 0 0",
                     n_line_done, n_err_len, n_err_overrun);
        end
    endtask

    task automatic test_short_line();
        clear_counts();
        random_line();
        top_exp[COLUMNS-1] = 3'd0;
        bot_exp[COLUMNS-1] = 3'd0;
        push_line(4'd9);
        for (int i = 0; i < COLUMNS - 1; i++) shift_col(top_exp[i], bot_exp[i]);
        pulse_latch(4'd9);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || n_err_len != 1 || n_line_done != 1) begin
            failures++;
            $display("FAIL short_line got left=%0d len=%0d done=%0d required 0 1 1",
                     exp_q.size(), n_err_len, n_line_done);
        end
    endtask

    task automatic test_long_line();
        clear_counts();
        random_line();
        top_exp[0] = top_exp[COLUMNS-1];
        bot_exp[0] = bot_exp[COLUMNS-1];
        push_line(4'd15);
        for (int i = 0; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        shift_col(~top_exp[COLUMNS-1], ~bot_exp[COLUMNS-1]);
        pulse_latch(4'd15);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || n_err_len != 1 || n_line_done != 1) begin
            failures++;
            $display("FAIL long_line got left=%0d len=%0d done=%0d required 0 1 1",
                     exp_q.size(), n_err_len, n_line_done);
        end
    endtask

    task automatic test_stall();
        clear_counts();
        random_line();
        push_line(4'd0);
        for (int i = 0; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        ready_toggle = 1;
        pulse_latch(4'd0);
        wait_drain();
        ready_toggle = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || n_acc != 2 * COLUMNS || n_line_done != 1) begin
            failures++;
            $display("FAIL stall_drain got left=%0d acc=%0d done=%0d required 0 128 1",
                     exp_q.size(), n_acc, n_line_done);
        end
    endtask

    task automatic test_overrun();
        logic [2:0] part0 [5];
        logic [2:0] part1 [5];
        clear_counts();
        random_line();
        push_line(4'd5);
        for (int i = 0; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        pulse_latch(4'd5);
        for (int i = 0; i < 5; i++) begin
            part0[i] = 3'($urandom_range(0, 7));
            part1[i] = 3'($urandom_range(0, 7));
            shift_col(part0[i], part1[i]);
        end
        pulse_latch(4'd6);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || n_err_overrun != 1 || n_line_done != 1 || n_err_len != 0) begin
            failures++;
            $display("FAIL overrun got left=%0d ovr=%0d done=%0d len=%0d required 0 1 1 0",
                     exp_q.size(), n_err_overrun, n_line_done, n_err_len);
        end
        clear_counts();
        random_line();
        for (int i = 0; i < 5; i++) begin
            top_exp[i] = part0[i];
            bot_exp[i] = part1[i];
        end
        push_line(4'd7);
        for (int i = 5; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        pulse_latch(4'd7);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || n_err_len != 0 || n_line_done != 1 || n_err_overrun != 0) begin
            failures++;
            $display("FAIL overrun_resume got left=%0d len=%0d done=%0d ovr=%0d required 0 0 1 0",
                     exp_q.size(), n_err_len, n_line_done, n_err_overrun);
        end
    endtask

    task automatic test_oe();
        clear_counts();
        @(negedge clk);
        hub_oe = 1'b0;
        repeat (32) @(negedge clk);
        hub_oe = 1'b1;
        for (int k = 0; k < 20 && n_oe_valid == 0; k++) @(negedge clk);
        checks++;
        if (n_oe_valid != 1 || last_oe !== 16'd32) begin
            failures++;
            $display("FAIL oe_32 got valid=%0d cycles=%0d required 1 32", n_oe_valid, last_oe);
        end
        clear_counts();
        hub_oe = 1'b0;
        repeat (70000) @(negedge clk);
        hub_oe = 1'b1;
        for (int k = 0; k < 20 && n_oe_valid == 0; k++) @(negedge clk);
        checks++;
        if (n_oe_valid != 1 || last_oe !== 16'hFFFF) begin
            failures++;
            $display("FAIL oe_saturate got valid=%0d cycles=%h required 1 ffff", n_oe_valid, last_oe);
        end
    endtask

    task automatic test_reset_mid_drain();
        random_line();
        push_line(4'd2);
        for (int i = 0; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        pulse_latch(4'd2);
        for (int k = 0; k < 400 && exp_q.size() > COLUMNS; k++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pix_valid !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_abort got valid=%0b state=%0d required 0 0", pix_valid, dbg_state);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_counts();
        random_line();
        push_line(4'd12);
        for (int i = 0; i < COLUMNS; i++) shift_col(top_exp[i], bot_exp[i]);
        pulse_latch(4'd12);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || n_line_done != 1 || n_err_len != 0 || n_err_overrun != 0) begin
            failures++;
            $display("FAIL reset_recover got left=%0d done=%0d len=%0d ovr=%0d required 0 1 0 0",
                     exp_q.size(), n_line_done, n_err_len, n_err_overrun);
        end
    endtask

    initial begin
        rst       = 1'b1;
        hub_clk   = 1'b0;
        hub_latch = 1'b0;
        hub_oe    = 1'b1;
        hub_addr  = '0;
        hub_rgb0  = '0;
        hub_rgb1  = '0;
        clear_counts();
        test_reset();
        test_idle();
        test_full_line();
        test_short_line();
        test_long_line();
        test_stall();
        test_overrun();
        test_oe();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
